// File: rtl/mac_pe_seq_if.sv
// mac_pe_seq_if: the x input stream and the y result stream of one MAC job.
//   s_valid/s_ready/s_data : signed 8-bit x values flowing into the sequencer
//   m_valid/m_ready/m_data : signed 32-bit results flowing out of the sequencer
// modport slave  : the sequencer side (consumes x, produces y)
// modport master : the DMA / job-source side (produces x, consumes y)
interface mac_pe_seq_if;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;

    modport slave  (input  s_valid, s_data, m_ready,
                    output s_ready, m_valid, m_data);
    modport master (output s_valid, s_data, m_ready,
                    input  s_ready, m_valid, m_data);
endinterface

// File: rtl/mac_pe_seq.sv
// mac_pe_seq: runs one single-PE MAC job. Loads the weight into the PE, streams
// cfg_len x values through it with a constant bias on y_in, and buffers the
// results in a small FIFO that drains onto a ready/valid stream.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         1-cycle job control pulses
//   cfg_weight/bias/len  job configuration, sampled on start
//   busy, done, aborted  job status (done/aborted are 1-cycle pulses)
//   err_spurious         sticky: PE returned a result with none in flight
//   issued_cnt           elements issued to the PE in the current/last job
//   bus                  x stream in (s_*) and y stream out (m_*)
//   pe_*                 registered drive to the PE, and its result return
module mac_pe_seq #(
    parameter int OUT_DEPTH = 4,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       cfg_weight,
    input  logic [31:0]      cfg_bias,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err_spurious,
    output logic [LEN_W-1:0] issued_cnt,
    mac_pe_seq_if.slave      bus,
    output logic             pe_load_weight,
    output logic             pe_valid_in,
    output logic [7:0]       pe_x_in,
    output logic [31:0]      pe_y_in,
    input  logic [31:0]      pe_y_out,
    input  logic             pe_valid_out
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOADW, S_STREAM, S_DRAIN, S_DONE, S_ABORT, S_ABORTED
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;
    logic             s_ready_q, s_ready_d;
    logic             load_q, load_d;
    logic             pvalid_q, pvalid_d;
    logic [7:0]       px_q, px_d;
    logic [31:0]      py_q, py_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       w_q, w_d;
    logic [31:0]      bias_q, bias_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [31:0]      mem_q [OUT_DEPTH];
    logic [31:0]      mem_d [OUT_DEPTH];

    logic accept, ret, spur, push, pop, abort_take;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        err_d      = err_q;
        load_d     = 1'b0;
        pvalid_d   = 1'b0;
        px_d       = px_q;
        py_d       = py_q;
        issued_d   = issued_q;
        len_d      = len_q;
        w_d        = w_q;
        bias_d     = bias_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        mem_d      = mem_q;

        // s_ready_q is only ever high in STREAM
        accept     = s_ready_q && bus.s_valid;
        ret        = pe_valid_out && (inflight_q != '0);
        spur       = pe_valid_out && (inflight_q == '0);
        // results returning during an abort are discarded, not buffered
        push       = ret && (state_q != S_ABORT);
        pop        = (cnt_q != '0) && bus.m_ready;
        abort_take = abort && (state_q == S_LOADW || state_q == S_STREAM ||
                               state_q == S_DRAIN);

        if (accept) begin
            pvalid_d = 1'b1;
            px_d     = bus.s_data;
            py_d     = bias_q;
            issued_d = issued_q + LEN_W'(1);
        end
        inflight_d = inflight_q + CW'(accept) - CW'(ret);

        if (push) begin
            mem_d[wr_q] = pe_y_out;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) rd_d = rd_q + PW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        if (spur) err_d = 1'b1;

        case (state_q)
            S_IDLE: if (start) begin
                len_d    = cfg_len;
                w_d      = cfg_weight;
                bias_d   = cfg_bias;
                issued_d = '0;
                err_d    = 1'b0;
                busy_d   = 1'b1;
                state_d  = (cfg_len != '0) ? S_LOADW : S_DONE;
            end
            S_LOADW: begin
                if (abort_take) state_d = S_ABORT;
                else begin
                    load_d  = 1'b1;
                    px_d    = w_q;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (abort_take)            state_d = S_ABORT;
                else if (issued_d == len_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_take) state_d = S_ABORT;
                else if (inflight_q == '0 && cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ABORT: if (inflight_q == '0) state_d = S_ABORTED;
            S_ABORTED: begin
                aborted_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // abort flushes the buffer; a pop in the abort cycle has already left
        if (abort_take) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end

        // Credit rule: only issue while every in-flight or buffered result
        // still has its own FIFO slot, so the PE never needs back-pressure.
        s_ready_d = (state_d == S_STREAM) && (issued_d < len_d) &&
                    (({1'b0, cnt_d} + {1'b0, inflight_d}) < (CW+1)'(OUT_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            load_q     <= 1'b0;
            pvalid_q   <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            issued_q   <= '0;
            len_q      <= '0;
            w_q        <= '0;
            bias_q     <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            err_q      <= err_d;
            s_ready_q  <= s_ready_d;
            load_q     <= load_d;
            pvalid_q   <= pvalid_d;
            px_q       <= px_d;
            py_q       <= py_d;
            issued_q   <= issued_d;
            len_q      <= len_d;
            w_q        <= w_d;
            bias_q     <= bias_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign err_spurious   = err_q;
    assign issued_cnt     = issued_q;
    assign bus.s_ready    = s_ready_q;
    assign bus.m_valid    = (cnt_q != '0);
    assign bus.m_data     = mem_q[rd_q];
    assign pe_load_weight = load_q;
    assign pe_valid_in    = pvalid_q;
    assign pe_x_in        = px_q;
    assign pe_y_in        = py_q;
endmodule

// File: tb/tb_mac_pe_seq.sv
module tb_mac_pe_seq;
    localparam int OUT_DEPTH = 4;
    localparam int LEN_W     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start = 1'b0, abort = 1'b0;
    logic [7:0]       cfg_weight = '0;
    logic [31:0]      cfg_bias = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             busy, done, aborted, err_spurious;
    logic [LEN_W-1:0] issued_cnt;
    logic             pe_load_weight, pe_valid_in, pe_valid_out;
    logic [7:0]       pe_x_in;
    logic [31:0]      pe_y_in, pe_y_out;

    mac_pe_seq_if bus();

    mac_pe_seq #(.OUT_DEPTH(OUT_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_weight(cfg_weight), .cfg_bias(cfg_bias), .cfg_len(cfg_len),
        .busy(busy), .done(done), .aborted(aborted), .err_spurious(err_spurious),
        .issued_cnt(issued_cnt), .bus(bus),
        .pe_load_weight(pe_load_weight), .pe_valid_in(pe_valid_in),
        .pe_x_in(pe_x_in), .pe_y_in(pe_y_in),
        .pe_y_out(pe_y_out), .pe_valid_out(pe_valid_out)
    );

    // PE: y = y_in + w*x after a fixed latency of lat cycles (1..3)
    int               lat = 1;
    logic             force_spur = 1'b0;
    logic signed [7:0] pe_w;
    logic [2:0]       pv;
    logic [31:0]      py [0:2];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_w <= '0; pv <= '0;
            py[0] <= '0; py[1] <= '0; py[2] <= '0;
        end else begin
            if (pe_load_weight) pe_w <= pe_x_in;
            pv    <= {pv[1:0], pe_valid_in};
            py[0] <= $signed(pe_y_in) + int'(pe_w) * int'($signed(pe_x_in));
            py[1] <= py[0];
            py[2] <= py[1];
        end
    end
    assign pe_valid_out = pv[lat-1] | force_spur;
    assign pe_y_out     = py[lat-1];

    int n_pass = 0, n_tot = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, expv);
    endtask

    // Reference model: every accepted x yields bias + w*x, delivered in order.
    logic signed [7:0] cur_w = '0;
    logic [31:0]       cur_b = '0;
    logic [31:0]       exp_q[$];
    logic [31:0]       got_q[$];
    logic [7:0]        xs[$];
    int  acc_cnt = 0, pop_cnt = 0, done_cnt = 0, abrt_cnt = 0, lw_cnt = 0;
    bit  prev_fire = 0, in_abort = 0;
    logic [7:0] prev_x = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_fire = 0;
            in_abort  = 0;
        end else begin
            chk("pe_valid_in", pe_valid_in, prev_fire);
            if (prev_fire) begin
                chk("pe_x_in", pe_x_in, prev_x);
                chk("pe_y_in", pe_y_in, cur_b);
            end
            if (in_abort) chk("m_valid_in_abort", bus.m_valid, 0);
            prev_fire = bus.s_valid && bus.s_ready;
            prev_x    = bus.s_data;
            if (prev_fire) begin
                exp_q.push_back(cur_b + int'(cur_w) * int'($signed(bus.s_data)));
                acc_cnt++;
            end
            if (bus.m_valid && bus.m_ready) begin
                got_q.push_back(bus.m_data);
                pop_cnt++;
                if (exp_q.size() == 0) chk("m_unexpected", 1, 0);
                else chk("m_data", bus.m_data, exp_q.pop_front());
            end
            if (prev_fire) chk("credit", exp_q.size() > OUT_DEPTH, 0);
            if (abort) begin exp_q.delete(); in_abort = 1; end
            if (done || aborted) in_abort = 0;
            if (done) done_cnt++;
            if (aborted) abrt_cnt++;
            if (pe_load_weight) lw_cnt++;
        end
    end

    task automatic chk_reset(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_aborted"}, aborted, 0);
        chk({p, "_err"}, err_spurious, 0);
        chk({p, "_s_ready"}, bus.s_ready, 0);
        chk({p, "_m_valid"}, bus.m_valid, 0);
        chk({p, "_m_data"}, bus.m_data, 0);
        chk({p, "_load_w"}, pe_load_weight, 0);
        chk({p, "_pe_valid"}, pe_valid_in, 0);
        chk({p, "_pe_x"}, pe_x_in, 0);
        chk({p, "_pe_y"}, pe_y_in, 0);
        chk({p, "_issued"}, issued_cnt, 0);
    endtask

    // res: 1 = done, 2 = aborted, 0 = timeout
    task automatic run_job(input logic [7:0] w, input logic [31:0] b, input int len,
                           input int vprob, input int rprob, input int abort_at,
                           input int mhold, output int res);
        int   loc_acc, idx;
        logic fire;
        bit   ab_sent;
        loc_acc = 0; idx = 0; ab_sent = 0; res = 0;
        @(posedge clk); #1;
        cur_w = w; cur_b = b; acc_cnt = 0; pop_cnt = 0; got_q.delete();
        cfg_weight = w; cfg_bias = b; cfg_len = LEN_W'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.s_valid = (idx < xs.size()) && ($urandom_range(99) < vprob);
            bus.s_data  = bus.s_valid ? xs[idx] : 8'($urandom);
            bus.m_ready = (cyc >= mhold) && ($urandom_range(99) < rprob);
            abort = 1'b0;
            if (abort_at >= 0 && !ab_sent && loc_acc >= abort_at) begin
                abort = 1'b1; ab_sent = 1; bus.s_valid = 1'b0;
            end
            @(negedge clk);
            fire = bus.s_valid && bus.s_ready;
            if (fire) loc_acc++;
            if (mhold > 0 && cyc == mhold - 1) begin
                chk("hold_accepts", loc_acc, OUT_DEPTH);
                chk("hold_s_ready", bus.s_ready, 0);
            end
            if (done || aborted) begin res = done ? 1 : 2; break; end
            @(posedge clk); #1;
            if (fire) idx++;
        end
        if (res == 0) chk("job_timeout", 0, 1);
        @(posedge clk); #1;
        abort = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int res, d0, a0, lw0, len, ab;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset("post_rst");

        // 1: basic job, swept over PE latency
        for (int l = 1; l <= 3; l++) begin
            lat = l;
            xs = {8'd1, 8'd2, 8'hFC};
            d0 = done_cnt;
            run_job(8'd3, 32'd10, 3, 100, 100, -1, 0, res);
            chk("t1_res", res, 1);
            chk("t1_n", got_q.size(), 3);
            if (got_q.size() == 3) begin
                chk("t1_y0", got_q[0], 32'd13);
                chk("t1_y1", got_q[1], 32'd16);
                chk("t1_y2", got_q[2], 32'hFFFF_FFFE);
            end
            chk("t1_done_once", done_cnt - d0, 1);
            chk("t1_issued", issued_cnt, 3);
            chk("t1_busy", busy, 0);
        end

        // 2: extreme operands
        lat = 2;
        xs = {8'h80};
        run_job(8'h80, 32'd0, 1, 100, 100, -1, 0, res);
        chk("t2a_res", res, 1);
        chk("t2a_y", (got_q.size() == 1) ? got_q[0] : 32'hDEAD, 32'd16384);
        xs = {8'hFF};
        run_job(8'h7F, 32'hFFFF_FFFB, 1, 100, 100, -1, 0, res);
        chk("t2b_res", res, 1);
        chk("t2b_y", (got_q.size() == 1) ? got_q[0] : 32'hDEAD, 32'hFFFF_FF7C);

        // 3: consumer stalled, credit caps issues at OUT_DEPTH
        lat = 3;
        xs.delete();
        for (int i = 0; i < 8; i++) xs.push_back(8'($urandom));
        run_job(8'($urandom), $urandom, 8, 100, 100, -1, 30, res);
        chk("t3_res", res, 1);
        chk("t3_n", got_q.size(), 8);
        chk("t3_left", exp_q.size(), 0);
        chk("t3_issued", issued_cnt, 8);

        // 4: zero-length job
        @(posedge clk); #1;
        lw0 = lw_cnt; d0 = done_cnt;
        cfg_len = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_busy_t1", busy, 1);
        chk("t4_done_t1", done, 0);
        @(negedge clk);
        chk("t4_done_t2", done, 1);
        chk("t4_busy_t2", busy, 0);
        @(negedge clk);
        chk("t4_done_t3", done, 0);
        chk("t4_busy_t3", busy, 0);
        @(posedge clk); #1;
        chk("t4_no_load", lw_cnt - lw0, 0);
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_issued", issued_cnt, 0);

        // 5: abort mid-stream
        lat = 2;
        xs.delete();
        for (int i = 0; i < 10; i++) xs.push_back(8'($urandom));
        d0 = done_cnt; a0 = abrt_cnt;
        run_job(8'($urandom), $urandom, 10, 100, 100, 5, 0, res);
        chk("t5_res", res, 2);
        chk("t5_issued", issued_cnt, 5);
        chk("t5_accepts", acc_cnt, 5);
        chk("t5_aborted_once", abrt_cnt - a0, 1);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_m_valid", bus.m_valid, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_quiet", acc_cnt, 5);

        // randomized jobs
        for (int j = 0; j < 25; j++) begin
            lat = $urandom_range(3, 1);
            len = $urandom_range(12, 1);
            ab  = ($urandom_range(3) == 0) ? int'($urandom_range(len - 1)) : -1;
            xs.delete();
            for (int i = 0; i < len; i++) xs.push_back(8'($urandom));
            d0 = done_cnt; a0 = abrt_cnt;
            run_job(8'($urandom), $urandom, len, $urandom_range(100, 30),
                    $urandom_range(100, 20), ab, 0, res);
            chk("rnd_one_end", (done_cnt - d0) + (abrt_cnt - a0), 1);
            if (res == 1) begin
                chk("rnd_issued", issued_cnt, len);
                chk("rnd_delivered", got_q.size(), len);
            end else if (res == 2) begin
                chk("rnd_ab_issued", issued_cnt, acc_cnt);
            end
            chk("rnd_busy", busy, 0);
            chk("rnd_err", err_spurious, 0);
        end

        // 6: spurious PE result while idle, cleared by the next start
        lat = 1;
        @(posedge clk); #1;
        force_spur = 1'b1;
        @(posedge clk); #1;
        force_spur = 1'b0;
        @(negedge clk);
        chk("t6_err_set", err_spurious, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_err_sticky", err_spurious, 1);
        xs = {8'd7};
        run_job(8'd2, 32'd1, 1, 100, 100, -1, 0, res);
        chk("t6_res", res, 1);
        chk("t6_err_clr", err_spurious, 0);
        chk("t6_y", (got_q.size() == 1) ? got_q[0] : 32'hDEAD, 32'd15);

        // reset in the middle of a stream
        @(posedge clk); #1;
        cur_w = 8'sd5; cur_b = 32'd1;
        cfg_weight = 8'd5; cfg_bias = 32'd1; cfg_len = LEN_W'(10); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus.s_valid = 1'b1; bus.s_data = 8'd2; bus.m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset("rst_mid_after");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
